// File: rtl/prng_req_arbiter.sv
// Sequences a shared PRNG core (seed load, warm-up, reseed) and hands one word per
// round-robin grant. Optional served-word counter enabled by PRNG_ARB_STATS_EN.
module prng_req_arbiter #(
   parameter int unsigned       NUM_REQ = 4,
   parameter int unsigned       WIDTH   = 8,
   parameter int unsigned       SEED_W  = 16,
   parameter logic [SEED_W-1:0] SEED    = 16'hACE1,
   parameter int unsigned       WARMUP  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_ena,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_rnd_valid,
   output logic [WIDTH-1:0]   o_rnd_data,
   input  logic               i_reseed_req,
   input  logic [SEED_W-1:0]  i_reseed_val,
   output logic               o_prng_load,
   output logic [SEED_W-1:0]  o_prng_seed,
   output logic               o_prng_step,
   input  logic [WIDTH-1:0]   i_prng_q,
   output logic               o_busy,
   output logic [15:0]        o_served_cnt
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [CW-1:0]      WARM_INIT = CW'((WARMUP > 0) ? (WARMUP - 1) : 0);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

   typedef enum logic [1:0] {StLoad, StWarm, StIdle, StServe} state_e;

   state_e            r_state, w_state_d;
   logic [SEED_W-1:0] r_seed;
   logic              r_pend, w_pend_d;
   logic [IW-1:0]     r_last, w_last_d;
   logic [IW-1:0]     r_winner, w_winner_d;
   logic [IW-1:0]     w_winner;
   logic              w_any;
   logic [CW-1:0]     r_warm_cnt, w_warm_d;
   logic              w_run;

   // Round-robin search starting just after the last served requester.
   always_comb begin
      int idx;
      idx      = 0;
      w_winner = r_last;
      w_any    = 1'b0;
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
         idx = (int'(r_last) + i) % int'(NUM_REQ);
         if (!w_any && i_req[IW'(idx)]) begin
            w_any    = 1'b1;
            w_winner = IW'(idx);
         end
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_warm_d   = r_warm_cnt;
      w_last_d   = r_last;
      w_winner_d = r_winner;
      w_pend_d   = r_pend;
      if (i_ena) begin
         unique case (r_state)
            StLoad: begin
               w_pend_d = 1'b0;
               if (WARMUP == 0) begin
                  w_state_d = StIdle;
               end else begin
                  w_state_d = StWarm;
                  w_warm_d  = WARM_INIT;
               end
            end
            StWarm: begin
               if (r_warm_cnt == '0) w_state_d = StIdle;
               else                  w_warm_d  = r_warm_cnt - 1'b1;
            end
            StIdle: begin
               if (r_pend || i_reseed_req) begin
                  w_state_d = StLoad;
               end else if (w_any) begin
                  w_state_d  = StServe;
                  w_winner_d = w_winner;
               end
            end
            StServe: begin
               w_last_d  = r_winner;
               w_state_d = StIdle;
            end
            default: w_state_d = StLoad;
         endcase
      end
      // Capture is honoured even while disabled and overrides the LOAD clear.
      if (i_reseed_req) w_pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StLoad;
         r_seed     <= SEED;
         r_pend     <= 1'b0;
         r_last     <= IW'(NUM_REQ - 1);
         r_winner   <= '0;
         r_warm_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_pend     <= w_pend_d;
         r_last     <= w_last_d;
         r_winner   <= w_winner_d;
         r_warm_cnt <= w_warm_d;
         if (i_reseed_req) r_seed <= i_reseed_val;
      end
   end

   assign w_run       = i_ena && !rst;
   assign o_prng_load = w_run && (r_state == StLoad);
   assign o_prng_step = w_run && ((r_state == StWarm) || (r_state == StServe));
   assign o_rnd_valid = w_run && (r_state == StServe);
   assign o_gnt       = o_rnd_valid ? (ONE_HOT0 << r_winner) : '0;
   assign o_rnd_data  = o_rnd_valid ? i_prng_q : '0;
   assign o_prng_seed = r_seed;
   assign o_busy      = !rst && (r_state != StIdle);

`ifdef PRNG_ARB_STATS_EN
   logic [15:0] r_served_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_served_cnt <= '0;
      end else if (i_ena) begin
         if (r_state == StLoad) begin
            r_served_cnt <= '0;
         end else if ((r_state == StServe) && (r_served_cnt != 16'hFFFF)) begin
            r_served_cnt <= r_served_cnt + 16'd1;
         end
      end
   end

   assign o_served_cnt = r_served_cnt;
`else
   assign o_served_cnt = '0;
`endif

endmodule

// File: tb/tb_prng_req_arbiter.sv
// Bench for prng_req_arbiter: transaction-level reference model feeds a grant scoreboard,
// a separate monitor pops and compares whenever the DUT presents a word.
module tb_prng_req_arbiter;

   localparam int          N     = 4;
   localparam int          W     = 8;
   localparam int          SW    = 16;
   localparam int          WU    = 16;
   localparam logic [15:0] SEED0 = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst, ena, reseed_req;
   logic [N-1:0]  req, gnt;
   logic          rnd_valid, prng_load, prng_step, busy;
   logic [W-1:0]  rnd_data, prng_q;
   logic [SW-1:0] reseed_val, prng_seed;
   logic [15:0]   served_cnt;

   always #5 clk = ~clk;

   prng_req_arbiter #(
      .NUM_REQ(N), .WIDTH(W), .SEED_W(SW), .SEED(SEED0), .WARMUP(WU)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_ena        (ena),
      .i_req        (req),
      .o_gnt        (gnt),
      .o_rnd_valid  (rnd_valid),
      .o_rnd_data   (rnd_data),
      .i_reseed_req (reseed_req),
      .i_reseed_val (reseed_val),
      .o_prng_load  (prng_load),
      .o_prng_seed  (prng_seed),
      .o_prng_step  (prng_step),
      .i_prng_q     (prng_q),
      .o_busy       (busy),
      .o_served_cnt (served_cnt)
   );

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Stand-in PRNG core driven by the DUT strobes.
   logic [15:0] core = 16'h0000;
   always @(posedge clk) begin
      if (prng_load)      core <= prng_seed;
      else if (prng_step) core <= lfsr_next(core);
   end
   assign prng_q = core[W-1:0];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [N-1:0] g;
      logic [W-1:0] d;
   } exp_t;
   exp_t sb[$];

   // Reference model: pending work expressed as counts rather than a state machine.
   logic [15:0] m_seed = SEED0;
   logic [15:0] m_lfsr = 16'h0000;
   bit          m_pend = 1'b0;
   bit          m_load = 1'b1;
   int          m_warm = 0;
   int          m_serve = -1;
   int          m_last = N - 1;
   int          m_served = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit e, input logic [N-1:0] q, input bit rs,
                        input logic [15:0] rv);
      bit   idle;
      int   w;
      exp_t x;
      @(negedge clk);
      rst = r; ena = e; req = q; reseed_req = rs; reseed_val = rv;
      #1;
      if (r) begin
         check("prng_load_rst", 32'(prng_load), 32'd0);
         check("prng_step_rst", 32'(prng_step), 32'd0);
         check("busy_rst", 32'(busy), 32'd0);
      end else begin
         idle = !m_load && (m_warm == 0) && (m_serve < 0);
         check("prng_load", 32'(prng_load), 32'(e && m_load));
         check("prng_step", 32'(prng_step), 32'(e && ((m_warm > 0) || (m_serve >= 0))));
         check("busy", 32'(busy), 32'(!idle));
         check("prng_seed", 32'(prng_seed), 32'(m_seed));
`ifdef PRNG_ARB_STATS_EN
         check("served_cnt", 32'(served_cnt), 32'(m_served));
`else
         check("served_cnt", 32'(served_cnt), 32'd0);
`endif
      end
      if (r) begin
         m_seed = SEED0; m_pend = 1'b0; m_load = 1'b1; m_warm = 0;
         m_serve = -1; m_last = N - 1; m_served = 0;
         sb.delete();
      end else begin
         if (e) begin
            if (m_load) begin
               m_lfsr = m_seed; m_load = 1'b0; m_warm = WU; m_pend = 1'b0; m_served = 0;
            end else if (m_warm > 0) begin
               m_lfsr = lfsr_next(m_lfsr); m_warm--;
            end else if (m_serve >= 0) begin
               m_lfsr = lfsr_next(m_lfsr); m_last = m_serve; m_serve = -1;
               if (m_served < 65535) m_served++;
            end else if (m_pend || rs) begin
               m_load = 1'b1;
            end else if (q != '0) begin
               w = -1;
               for (int i = 1; i <= N; i++) begin
                  if (w < 0 && q[(m_last + i) % N]) w = (m_last + i) % N;
               end
               m_serve = w;
               x.g = '0;
               x.g[w] = 1'b1;
               x.d = m_lfsr[W-1:0];
               sb.push_back(x);
            end
         end
         if (rs) begin
            m_pend = 1'b1; m_seed = rv;
         end
      end
   endtask

   task automatic wait_serve(input logic [N-1:0] q);
      int n = 0;
      while (m_serve < 0 && n < 12) begin
         cycle(1'b0, 1'b1, q, 1'b0, 16'h0);
         n++;
      end
      checks++;
      if (m_serve < 0) begin
         errors++;
         $display("FAIL wait_serve: no grant scheduled within %0d cycles", n);
      end
   endtask

   // Monitor: compares each presented word against the scoreboard head.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (rnd_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: got gnt %b required none at %0t", gnt, $time);
            end else begin
               x = sb.pop_front();
               check("gnt", 32'(gnt), 32'(x.g));
               check("rnd_data", 32'(rnd_data), 32'(x.d));
            end
         end else begin
            check("gnt_idle", 32'(gnt), 32'd0);
            check("rnd_data_idle", 32'(rnd_data), 32'd0);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; ena = 1'b0; req = '0; reseed_req = 1'b0; reseed_val = '0;
      repeat (2) cycle(1'b1, 1'b1, 4'b0000, 1'b0, 16'h0);
      repeat (20) cycle(1'b0, 1'b1, 4'b0000, 1'b0, 16'h0);
      repeat (12) cycle(1'b0, 1'b1, 4'b1111, 1'b0, 16'h0);
      repeat (6) cycle(1'b0, 1'b1, 4'b0100, 1'b0, 16'h0);
      repeat (8) cycle(1'b0, 1'b1, 4'b0101, 1'b0, 16'h0);
      // Reseed while serving, then stall the warm-up after its 5th step.
      wait_serve(4'b1111);
      cycle(1'b0, 1'b1, 4'b1111, 1'b1, 16'h1234);
      n = 0;
      while (m_warm != WU - 5 && n < 24) begin
         cycle(1'b0, 1'b1, 4'b1111, 1'b0, 16'h0);
         n++;
      end
      checks++;
      if (m_warm != WU - 5) begin
         errors++;
         $display("FAIL warm_reach: warm-up not reached within %0d cycles", n);
      end
      repeat (3) cycle(1'b0, 1'b0, 4'b1111, 1'b0, 16'h0);
      repeat (24) cycle(1'b0, 1'b1, 4'b1111, 1'b0, 16'h0);
      // Reset during a grant cycle.
      wait_serve(4'b1111);
      cycle(1'b1, 1'b1, 4'b1111, 1'b0, 16'h0);
      repeat (24) cycle(1'b0, 1'b1, 4'b1111, 1'b0, 16'h0);
      repeat (3000) begin
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, N'($urandom),
               $urandom_range(0, 29) == 0, 16'($urandom));
      end
      repeat (40) cycle(1'b0, 1'b1, 4'b0000, 1'b0, 16'h0);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
